// File: rtl/tt_sweeper_if.sv
// tt_sweeper_if: sweep control, DUT stimulus/response and captured truth table.
// The sig signal is present only when TT_SWEEPER_SIG_EN is defined.
interface tt_sweeper_if #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 8
);
  localparam int TT_W = N_OUT * (1 << N_IN);

  logic              start;
  logic [N_IN-1:0]   x;
  logic [N_OUT-1:0]  f;
  logic              busy;
  logic              done;
  logic [TT_W-1:0]   tt;
  logic              tt_valid;
`ifdef TT_SWEEPER_SIG_EN
  logic [15:0]       sig;

  modport master (output start, f, input x, busy, done, tt, tt_valid, sig);
  modport slave  (input start, f, output x, busy, done, tt, tt_valid, sig);
`else
  modport master (output start, f, input x, busy, done, tt, tt_valid);
  modport slave  (input start, f, output x, busy, done, tt, tt_valid);
`endif
endinterface

// File: rtl/tt_sweeper.sv
// tt_sweeper: drives every input vector of a combinational DUT in turn, waits
// SETTLE cycles per vector, and captures the DUT outputs into a truth table.
// Optional feature macro: TT_SWEEPER_SIG_EN adds a 16-bit MISR signature
// (CRC-16-CCITT shift, MSB first, seeded 16'hFFFF) over the captured outputs.
module tt_sweeper #(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 8,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  tt_sweeper_if.slave  bus
);
  localparam int unsigned N_VEC = 1 << N_IN;
  localparam int          TT_W  = N_OUT * (1 << N_IN);
  localparam logic [3:0]  SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] V_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  localparam state_t ST_FIRST = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;

  state_t          state;
  logic [N_IN-1:0] v;
  logic [N_IN-1:0] x_q;
  logic [3:0]      cnt;
  logic            busy_q;
  logic            done_q;
  logic            tt_valid_q;
  logic [TT_W-1:0] tt_q;

`ifdef TT_SWEEPER_SIG_EN
  logic [15:0] sig_q;

  // One MSB-first shift of x^16+x^12+x^5+1 with no data input.
  function automatic logic [15:0] crc_step(input logic [15:0] s);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000);
  endfunction

  assign bus.sig = sig_q;
`endif

  assign bus.x        = x_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tt       = tt_q;
  assign bus.tt_valid = tt_valid_q;

  // Sweep sequencer: all outputs registered; done is a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      v          <= '0;
      x_q        <= '0;
      cnt        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tt_valid_q <= 1'b0;
      tt_q       <= '0;
`ifdef TT_SWEEPER_SIG_EN
      sig_q      <= '1;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            v          <= '0;
            cnt        <= '0;
            x_q        <= '0;
            busy_q     <= 1'b1;
            tt_valid_q <= 1'b0;
`ifdef TT_SWEEPER_SIG_EN
            sig_q      <= '1;
`endif
            state      <= ST_FIRST;
          end
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= ST_CAPTURE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_CAPTURE: begin
          for (int unsigned i = 0; i < N_VEC; i++) begin
            if (v == i[N_IN-1:0]) begin
              tt_q[i*N_OUT +: N_OUT] <= bus.f;
            end
          end
`ifdef TT_SWEEPER_SIG_EN
          sig_q <= crc_step(sig_q) ^ 16'(bus.f);
`endif
          if (v == V_LAST) begin
            x_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            tt_valid_q <= 1'b1;
            state      <= ST_DONE;
          end else begin
            v     <= v + 1'b1;
            x_q   <= v + 1'b1;
            state <= ST_FIRST;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tt_sweeper.sv
// Bench for tt_sweeper: one instance with SETTLE=1 and one with SETTLE=0,
// each wired to a lookup-table model of a 2-input, 8-output combinational DUT.
module tb_tt_sweeper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] lut [2][4];
  logic       st  [2];

  logic [1:0]  x_o   [2];
  logic        busy_o[2];
  logic        done_o[2];
  logic        tv_o  [2];
  logic [31:0] tt_o  [2];
`ifdef TT_SWEEPER_SIG_EN
  logic [15:0] sig_o [2];
`endif

  tt_sweeper_if #(.N_IN(2), .N_OUT(8)) b0 ();
  tt_sweeper_if #(.N_IN(2), .N_OUT(8)) b1 ();

  tt_sweeper #(.N_IN(2), .N_OUT(8), .SETTLE(1)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  tt_sweeper #(.N_IN(2), .N_OUT(8), .SETTLE(0)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  assign b0.start = st[0];
  assign b1.start = st[1];
  assign b0.f = lut[0][b0.x];
  assign b1.f = lut[1][b1.x];

  assign x_o[0] = b0.x;        assign x_o[1] = b1.x;
  assign busy_o[0] = b0.busy;  assign busy_o[1] = b1.busy;
  assign done_o[0] = b0.done;  assign done_o[1] = b1.done;
  assign tv_o[0] = b0.tt_valid; assign tv_o[1] = b1.tt_valid;
  assign tt_o[0] = b0.tt;      assign tt_o[1] = b1.tt;
`ifdef TT_SWEEPER_SIG_EN
  assign sig_o[0] = b0.sig;    assign sig_o[1] = b1.sig;

  // Signature reference: polynomial division of the register, then fold in f.
  function automatic logic [15:0] misr_model(input int d);
    int m;
    m = 'hFFFF;
    for (int v = 0; v < 4; v++) begin
      int fb;
      fb = (m >> 15) & 1;
      m = ((m << 1) & 'hFFFF) ^ (fb != 0 ? 'h1021 : 0) ^ int'(lut[d][v]);
    end
    return m[15:0];
  endfunction
`endif

  always #5 clk = ~clk;

  task automatic set_lut(input int d, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] e);
    lut[d][0] = a; lut[d][1] = b; lut[d][2] = c; lut[d][3] = e;
  endtask

  // Full sweep with cycle-by-cycle expectations derived from vector index and settle time.
  task automatic sweep(input int d, input string tag);
    int s;
    int total;
    logic [31:0] e_tt;
    s = (d == 0) ? 1 : 0;
    total = 4 * (s + 1) + 1;
    for (int v = 0; v < 4; v++) e_tt[v*8 +: 8] = lut[d][v];
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    for (int c = 1; c <= total; c++) begin
      int ex;
      ex = (c < total) ? (c - 1) / (s + 1) : 0;
      checks++;
      if (x_o[d] !== 2'(ex)) begin
        errors++;
        $display("FAIL %s x c=%0d: got %0h expected %0h", tag, c, x_o[d], ex);
      end
      checks++;
      if (busy_o[d] !== (c < total)) begin
        errors++;
        $display("FAIL %s busy c=%0d: got %0b expected %0b", tag, c, busy_o[d], c < total);
      end
      checks++;
      if (done_o[d] !== (c == total)) begin
        errors++;
        $display("FAIL %s done c=%0d: got %0b expected %0b", tag, c, done_o[d], c == total);
      end
      checks++;
      if (tv_o[d] !== (c == total)) begin
        errors++;
        $display("FAIL %s tt_valid c=%0d: got %0b expected %0b", tag, c, tv_o[d], c == total);
      end
      if (c == total) begin
        checks++;
        if (tt_o[d] !== e_tt) begin
          errors++;
          $display("FAIL %s tt: got %08h expected %08h", tag, tt_o[d], e_tt);
        end
`ifdef TT_SWEEPER_SIG_EN
        checks++;
        if (sig_o[d] !== misr_model(d)) begin
          errors++;
          $display("FAIL %s sig: got %04h expected %04h", tag, sig_o[d], misr_model(d));
        end
`endif
      end
      // start while busy or in DONE must be ignored
      st[d] = 1'($urandom_range(0, 1));
      if (c < total) @(negedge clk);
    end
    @(negedge clk);
    st[d] = 1'b0;
    checks++;
    if (done_o[d] !== 1'b0 || busy_o[d] !== 1'b0 || tv_o[d] !== 1'b1 || x_o[d] !== 2'd0) begin
      errors++;
      $display("FAIL %s post-done flags: got done=%0b busy=%0b tv=%0b x=%0h expected 0 0 1 0",
               tag, done_o[d], busy_o[d], tv_o[d], x_o[d]);
    end
    checks++;
    if (tt_o[d] !== e_tt) begin
      errors++;
      $display("FAIL %s tt hold: got %08h expected %08h", tag, tt_o[d], e_tt);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (x_o[d] !== 2'd0 || busy_o[d] !== 1'b0 || done_o[d] !== 1'b0 ||
          tv_o[d] !== 1'b0 || tt_o[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset d=%0d: got x=%0h busy=%0b done=%0b tv=%0b tt=%08h expected all 0",
                 d, x_o[d], busy_o[d], done_o[d], tv_o[d], tt_o[d]);
      end
`ifdef TT_SWEEPER_SIG_EN
      checks++;
      if (sig_o[d] !== 16'hFFFF) begin
        errors++;
        $display("FAIL reset sig d=%0d: got %04h expected ffff", d, sig_o[d]);
      end
`endif
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    set_lut(0, 8'hCE, 8'h7B, 8'h64, 8'h1A);
    set_lut(1, 8'hCE, 8'h7B, 8'h64, 8'h1A);
    sweep(0, "dflt");
    checks++;
    if (tt_o[0] !== 32'h1A647BCE) begin
      errors++;
      $display("FAIL dflt tt const: got %08h expected 1a647bce", tt_o[0]);
    end
    sweep(1, "settle0");
    checks++;
    if (tt_o[1] !== 32'h1A647BCE) begin
      errors++;
      $display("FAIL settle0 tt const: got %08h expected 1a647bce", tt_o[1]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int d = 0; d < 2; d++)
        for (int v = 0; v < 4; v++) lut[d][v] = 8'($urandom);
      sweep(r % 2, (r % 2 == 0) ? "rand_s1" : "rand_s0");
    end
  endtask

  task automatic test_extremes();
    set_lut(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    sweep(0, "ones");
    checks++;
    if (tt_o[0] !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL ones tt: got %08h expected ffffffff", tt_o[0]);
    end
    set_lut(0, 8'h00, 8'h00, 8'h00, 8'h00);
    sweep(0, "zeros");
    checks++;
    if (tt_o[0] !== 32'h00000000) begin
      errors++;
      $display("FAIL zeros tt: got %08h expected 00000000", tt_o[0]);
    end
  endtask

  task automatic test_back_to_back();
    int ndone;
    int wait_c;
    set_lut(0, 8'h11, 8'h22, 8'h33, 8'h44);
    ndone = 0;
    st[0] = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 9; c++) begin
      if (done_o[0] === 1'b1) ndone++;
      checks++;
      if (done_o[0] !== (c == 9)) begin
        errors++;
        $display("FAIL held done c=%0d: got %0b expected %0b", c, done_o[0], c == 9);
      end
      if (c < 9) @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (busy_o[0] !== 1'b0 || done_o[0] !== 1'b0 || tv_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL held idle: got busy=%0b done=%0b tv=%0b expected 0 0 1",
               busy_o[0], done_o[0], tv_o[0]);
    end
    @(negedge clk);
    st[0] = 1'b0;
    checks++;
    if (busy_o[0] !== 1'b1 || tv_o[0] !== 1'b0 || x_o[0] !== 2'd0) begin
      errors++;
      $display("FAIL held restart: got busy=%0b tv=%0b x=%0h expected 1 0 0",
               busy_o[0], tv_o[0], x_o[0]);
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL held done count: got %0d expected 1", ndone);
    end
    wait_c = 0;
    while (done_o[0] !== 1'b1 && wait_c < 20) begin
      @(negedge clk);
      wait_c++;
    end
    checks++;
    if (wait_c != 8) begin
      errors++;
      $display("FAIL held second sweep cycles: got %0d expected 8", wait_c);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    set_lut(0, 8'hA5, 8'h5A, 8'hC3, 8'h3C);
    sweep(0, "pre_rst");
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (x_o[0] !== 2'd1 || busy_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid x/busy before rst: got x=%0h busy=%0b expected 1 1", x_o[0], busy_o[0]);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (x_o[0] !== 2'd0 || busy_o[0] !== 1'b0 || tt_o[0] !== 32'h0 || tv_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL async rst: got x=%0h busy=%0b tt=%08h tv=%0b expected 0 0 0 0",
               x_o[0], busy_o[0], tt_o[0], tv_o[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || tv_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL after rst c=%0d: got done=%0b busy=%0b tv=%0b expected 0 0 0",
                 c, done_o[0], busy_o[0], tv_o[0]);
      end
    end
  endtask

  initial begin
    st[0] = 1'b0;
    st[1] = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int v = 0; v < 4; v++) lut[d][v] = 8'h00;
    test_reset();
    test_directed();
    test_random();
    test_extremes();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
